// File: rtl/dma_mem_responder_if.sv
// Handshake bundle between a DMA initiator (master) and the memory responder (slave).
// Read request, read beat, write request and write beat channels plus the sticky error flag.
interface dma_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           rd_req_addr;
    logic [4:0]            rd_req_len;
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [DATA_WIDTH-1:0] rd_rdata;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  rd_ready;

    logic [31:0]           wr_req_addr;
    logic [4:0]            wr_req_len;
    logic                  wr_req_valid;
    logic                  wr_req_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_last;
    logic                  wr_ready;

    logic                  err;

    modport slave (
        input  rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
        input  wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
        output rd_req_ready, rd_rdata, rd_valid, rd_last,
        output wr_req_ready, wr_ready, err
    );

    modport master (
        output rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
        output wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
        input  rd_req_ready, rd_rdata, rd_valid, rd_last,
        input  wr_req_ready, wr_ready, err
    );
endinterface

// File: rtl/dma_mem_responder.sv
// Burst memory responder: independent read and write burst engines sharing one
// read-first word memory, with a sticky flag for wr_last framing errors.
module dma_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10
) (
    input logic              clk,
    input logic              rst_n,
    dma_mem_responder_if.slave bus
);

    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic {R_IDLE, R_BURST} rd_state_t;
    typedef enum logic {W_IDLE, W_DATA}  wr_state_t;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    rd_state_t             r_rd_state;
    logic [MEM_AW-1:0]     r_rd_idx;
    logic [4:0]            r_rd_len;
    logic [5:0]            r_rd_issued;
    logic [4:0]            r_rd_returned;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic [DATA_WIDTH-1:0] r_rd_data;

    wr_state_t             r_wr_state;
    logic [MEM_AW-1:0]     r_wr_idx;
    logic [4:0]            r_wr_len;
    logic [4:0]            r_wr_cnt;
    logic                  r_err;

    logic w_rd_req_fire;
    logic w_rd_beat_fire;
    logic w_rd_issue;
    logic w_wr_req_fire;
    logic w_wr_fire;
    logic w_wr_final;
    logic w_unused_addr;

    assign w_rd_req_fire  = bus.rd_req_valid && (r_rd_state == R_IDLE);
    assign w_rd_beat_fire = r_rd_valid && bus.rd_ready;
    // A new RAM read only when the output register is empty or being drained this cycle.
    assign w_rd_issue     = (r_rd_state == R_BURST) &&
                            (r_rd_issued <= {1'b0, r_rd_len}) &&
                            (!r_rd_valid || bus.rd_ready);

    assign w_wr_req_fire  = bus.wr_req_valid && (r_wr_state == W_IDLE);
    assign w_wr_fire      = bus.wr_valid && (r_wr_state == W_DATA);
    assign w_wr_final     = (r_wr_cnt == r_wr_len);

    assign w_unused_addr  = ^{bus.rd_req_addr[31:MEM_AW+2], bus.rd_req_addr[1:0],
                              bus.wr_req_addr[31:MEM_AW+2], bus.wr_req_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_state    <= R_IDLE;
            r_rd_idx      <= '0;
            r_rd_len      <= '0;
            r_rd_issued   <= '0;
            r_rd_returned <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_last     <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_rd_req_fire) begin
                        r_rd_idx      <= bus.rd_req_addr[MEM_AW+1:2];
                        r_rd_len      <= bus.rd_req_len;
                        r_rd_issued   <= '0;
                        r_rd_returned <= '0;
                        r_rd_state    <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (w_rd_issue) begin
                        r_rd_data   <= r_mem[r_rd_idx];
                        r_rd_valid  <= 1'b1;
                        r_rd_last   <= (r_rd_issued == {1'b0, r_rd_len});
                        r_rd_idx    <= r_rd_idx + 1'b1;
                        r_rd_issued <= r_rd_issued + 6'd1;
                    end else if (w_rd_beat_fire) begin
                        r_rd_valid  <= 1'b0;
                        r_rd_last   <= 1'b0;
                    end
                    if (w_rd_beat_fire) begin
                        r_rd_returned <= r_rd_returned + 5'd1;
                        if (r_rd_returned == r_rd_len) begin
                            r_rd_state <= R_IDLE;
                        end
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // The final beat closes the burst regardless of wr_last; a disagreement only raises err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_state <= W_IDLE;
            r_wr_idx   <= '0;
            r_wr_len   <= '0;
            r_wr_cnt   <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_wr_req_fire) begin
                        r_wr_idx   <= bus.wr_req_addr[MEM_AW+1:2];
                        r_wr_len   <= bus.wr_req_len;
                        r_wr_cnt   <= '0;
                        r_wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_wr_fire) begin
                        r_wr_idx <= r_wr_idx + 1'b1;
                        r_wr_cnt <= r_wr_cnt + 5'd1;
                        if (bus.wr_last != w_wr_final) begin
                            r_err <= 1'b1;
                        end
                        if (w_wr_final) begin
                            r_wr_state <= W_IDLE;
                        end
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    // Memory has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_idx] <= bus.wr_data;
        end
    end

    assign bus.rd_req_ready = (r_rd_state == R_IDLE);
    assign bus.rd_rdata     = r_rd_data;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.rd_last      = r_rd_last;
    assign bus.wr_req_ready = (r_wr_state == W_IDLE);
    assign bus.wr_ready     = (r_wr_state == W_DATA);
    assign bus.err          = r_err;

endmodule

// File: doc/dma_mem_responder.md
DMA_MEM_RESPONDER -- requirements
Module: dma_mem_responder

Interface
REQ-001 Parameter DATA_WIDTH SHALL be 32 by default and SHALL set the width of read and write data.
REQ-002 Parameter MEM_AW SHALL be 10 by default and SHALL give the internal memory depth as 2^MEM_AW words of DATA_WIDTH bits.
REQ-003 Clock and reset SHALL be one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous reset, active low.
REQ-006 rd_req_addr  in  32  byte address of the first beat of a read burst.
REQ-007 rd_req_len  in  5  read beats minus 1.
REQ-008 rd_req_valid  in  1  read request offered.
REQ-009 rd_req_ready  out  1  read request accepted.
REQ-010 rd_rdata  out  32  read beat data.
REQ-011 rd_valid  out  1  read beat valid.
REQ-012 rd_last  out  1  final read beat.
REQ-013 rd_ready  in  1  initiator accepts read beat.
REQ-014 wr_req_addr  in  32  byte address of the first beat of a write burst.
REQ-015 wr_req_len  in  5  write beats minus 1.
REQ-016 wr_req_valid  in  1  write request offered.
REQ-017 wr_req_ready  out  1  write request accepted.
REQ-018 wr_data  in  32  write beat data.
REQ-019 wr_valid  in  1  write beat valid.
REQ-020 wr_last  in  1  initiator marks final write beat.
REQ-021 wr_ready  out  1  responder accepts write beat.
REQ-022 err  out  1  sticky protocol-error flag.

Function
REQ-023 Transfers SHALL occur only on cycles where the paired valid and ready signals are both high.
REQ-024 Word index SHALL be addr[MEM_AW+1:2]; addr[1:0] SHALL be ignored; the index SHALL increment by 1 per beat and wrap modulo 2^MEM_AW.
REQ-025 The read FSM SHALL have states R_IDLE and R_BURST; rd_req_ready SHALL be 1 exactly in R_IDLE.
REQ-026 A read request handshake SHALL latch the start index and len, clear the issued and returned beat counters, and enter R_BURST.
REQ-027 In R_BURST, a RAM read SHALL be issued when issued<=len and (!rd_valid || rd_ready); data SHALL be registered into rd_rdata with rd_valid=1 the next cycle.
REQ-028 The first rd_valid SHALL be at request-handshake cycle +2; with rd_ready held high, beats SHALL be back-to-back (len+1 beats in len+1 cycles).
REQ-029 When rd_valid=1 and rd_ready=0, rd_rdata, rd_valid and rd_last SHALL hold and no new read SHALL be issued.
REQ-030 rd_last SHALL be 1 only with the beat whose returned count equals len.
REQ-031 The handshake of the last read beat SHALL return the FSM to R_IDLE with rd_valid=0 next cycle; rd_req_ready SHALL be 1 that cycle.
REQ-032 The write FSM SHALL have states W_IDLE and W_DATA, independent of the read FSM; wr_req_ready SHALL be 1 only in W_IDLE, and wr_ready SHALL be 1 only in W_DATA.
REQ-033 A write request handshake SHALL latch the start index and len and clear the beat counter.
REQ-034 Each write-beat handshake SHALL write wr_data to the current index that cycle and increment the index and counter.
REQ-035 The beat with counter==len SHALL end the burst (to W_IDLE) whether or not wr_last is set.
REQ-036 err SHALL set when wr_last differs from (counter==len) on any write-beat handshake; once set, err SHALL remain 1 until reset.
REQ-037 The memory SHALL be read-first: a read and a write to the same index in one cycle SHALL return the old data.
REQ-038 Bursts SHALL not be split or reordered; at most one read and one write burst SHALL be outstanding.

Reset
REQ-039 While rst_n=0 at a clock edge, both FSMs SHALL enter IDLE, all counters SHALL clear and err SHALL clear.
REQ-040 In the cycle after that edge, outputs SHALL be: rd_req_ready=1, wr_req_ready=1, rd_valid=0, rd_last=0, wr_ready=0, err=0, rd_rdata=0.
REQ-041 Reset mid-burst SHALL abandon the burst with no further beats; memory contents SHALL be unaffected by reset.

Verification
REQ-042 Write burst addr 0x100, len 7, data 0..7 with wr_last on beat 7, then read burst addr 0x100, len 7 -> rd_rdata 0..7 back-to-back, rd_last on 8th beat, err=0.
REQ-043 Same read with rd_ready toggling 1,0,0,1 -> no beat lost or duplicated, and data holds while rd_ready=0.
REQ-044 Write len 3 at byte 0xFF8 (MEM_AW=10) -> words land at indices 1022, 1023, 0, 1, and reading back the same burst matches.
REQ-045 Write len 7 with wr_last on beat 3 -> err=1 after that beat, burst still takes 8 beats, err stays 1.
REQ-046 Assert rst_n=0 during beat 4 of a read len 7 -> next cycle rd_valid=0 and rd_req_ready=1, and a new read returns correct data.
REQ-047 Read and write bursts on overlapping addresses concurrently -> read returns pre-write data on same-cycle collisions and both channels complete.
